// File: rtl/sm2201_pkg.sv
// Shared definitions for the SM2201 ISA-to-CAMAC interface board: register
// window offsets, STATUS/RG2B bit positions, FSM states and the request /
// response bundles between the ISA register file and the CAMAC engine.
package sm2201_pkg;

  // Register window offsets (relative to BASE_ADDR)
  localparam logic [2:0] OFF_DATA_LO = 3'd0;
  localparam logic [2:0] OFF_RG2B    = 3'd1;
  localparam logic [2:0] OFF_DATA_HI = 3'd2;
  localparam logic [2:0] OFF_ADDR_LO = 3'd3;
  localparam logic [2:0] OFF_ADDR_HI = 3'd4;
  localparam logic [2:0] OFF_RSVD    = 3'd5;
  localparam logic [2:0] OFF_STATUS  = 3'd6;
  localparam logic [2:0] OFF_START   = 3'd7;

  // STATUS bit positions
  localparam int STS_BUSY = 0;
  localparam int STS_X    = 1;
  localparam int STS_Q    = 2;
  localparam int STS_TO   = 3;
  localparam int STS_LAM  = 4;

  // RG2B control bit positions
  localparam int RG2B_DIR = 0;
  localparam int RG2B_IE  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_LATCH,
    S_DONE
  } fsm_state_t;

  // Transfer request from the register file
  typedef struct packed {
    logic        start;
    logic        dir;
    logic [11:0] addr;
    logic [15:0] wdata;
  } xfer_req_t;

  // Transfer status / capture back to the register file
  typedef struct packed {
    logic        busy;
    logic        x;
    logic        q;
    logic        timeout;
    logic        cap_vld;
    logic [15:0] cap_data;
  } xfer_rsp_t;

  // Assemble the STATUS byte from engine status and the live LAM line
  function automatic logic [7:0] status_byte(input xfer_rsp_t r, input logic lam);
    logic [7:0] s;
    s           = 8'h00;
    s[STS_BUSY] = r.busy;
    s[STS_X]    = r.x;
    s[STS_Q]    = r.q;
    s[STS_TO]   = r.timeout;
    s[STS_LAM]  = lam;
    return s;
  endfunction

endpackage

// File: rtl/sm2201_camac_fsm.sv
// CAMAC transfer engine: one transfer per accepted start, with a bounded
// wait for cb_prr. Owns the CAMAC address/direction/data drivers and the
// X/Q/TIMEOUT status flags.
module sm2201_camac_fsm
  import sm2201_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        isa_clk,
  input  logic        isa_reset,
  input  xfer_req_t   req,
  input  logic        cb_prr,
  input  logic        cb_cx1,
  input  logic [15:0] cb_din,
  output logic [11:0] cb_addr,
  output logic        cb_b_b1,
  output logic [15:0] cb_dout,
  output xfer_rsp_t   rsp
);

  localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  fsm_state_t    state;
  logic [CW-1:0] cnt;
  logic          dir_q;
  logic          x_q;
  logic          q_q;
  logic          to_q;

  // Transfer sequencing; all CAMAC-side outputs are registered here
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      dir_q   <= 1'b0;
      x_q     <= 1'b0;
      q_q     <= 1'b0;
      to_q    <= 1'b0;
      cb_addr <= '0;
      cb_b_b1 <= 1'b0;
      cb_dout <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req.start) begin
            x_q   <= 1'b0;
            q_q   <= 1'b0;
            to_q  <= 1'b0;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          cb_addr <= req.addr;
          cb_b_b1 <= req.dir;
          dir_q   <= req.dir;
          cb_dout <= req.dir ? req.wdata : 16'h0000;
          cnt     <= '0;
          state   <= S_STROBE;
        end
        S_STROBE: begin
          if (!cb_prr) begin
            state <= S_LATCH;
          end else if (cnt == CNT_LAST) begin
            to_q  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LATCH: begin
          x_q   <= ~cb_cx1;
          q_q   <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          cb_b_b1 <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status and read-capture strobe; capture happens during LATCH on reads only
  always_comb begin
    rsp          = '0;
    rsp.busy     = (state != S_IDLE);
    rsp.x        = x_q;
    rsp.q        = q_q;
    rsp.timeout  = to_q;
    rsp.cap_vld  = (state == S_LATCH) && !dir_q;
    rsp.cap_data = cb_din;
  end

endmodule

// File: rtl/sm2201_interface_board.sv
// SM2201 ISA interface board top: ISA address latch and window decode,
// host register file, read-back mux, wait-state generation and IRQ.
// Optional build macro: SM2201_IRQ_EN (drives isa_irq[IRQ_LINE] from IE & LAM).
module sm2201_interface_board
  import sm2201_pkg::*;
#(
  parameter logic [9:0] BASE_ADDR      = 10'h100,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter int         IRQ_LINE       = 5
) (
  input  logic        isa_clk,
  input  logic        isa_reset,
  input  logic        isa_ior,
  input  logic        isa_iow,
  input  logic [9:0]  isa_addr,
  inout  wire  [7:0]  isa_data,
  input  logic        isa_ale,
  input  logic        isa_aen,
  output logic        isa_chrdy,
  output logic [7:0]  isa_irq,
  output logic        q_r_debug,
  input  logic        cb_prr,
  input  logic        cb_zk4,
  input  logic        cb_cx1,
  inout  wire  [15:0] cb_data,
  output logic [11:0] cb_addr,
  output logic        cb_b_b1
);

  localparam logic [7:0] IRQ_MASK = 8'(1) << IRQ_LINE;

  logic [9:0]  lat_addr;
  logic        iow_q;
  logic [10:0] addr_diff;
  logic        hit;
  logic [2:0]  off;
  logic        wr_stb;
  logic        rd_oe;
  logic [7:0]  rd_data;

  logic [7:0]  out_lo, out_hi, in_lo, in_hi, rg2b, addr_lo;
  logic [3:0]  addr_hi;

  logic        data_acc;
  logic        chrdy_hold;
  logic        irq_en;
  logic [15:0] cb_dout;

  xfer_req_t   req;
  xfer_rsp_t   rsp;

  // Address latch on ALE; iow delayed one clock for rising-edge detection
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      lat_addr <= '0;
      iow_q    <= 1'b1;
    end else begin
      if (isa_ale) lat_addr <= isa_addr;
      iow_q <= isa_iow;
    end
  end

  // Window decode: an address below BASE wraps into bit 10 and misses
  assign addr_diff = {1'b0, lat_addr} - {1'b0, BASE_ADDR};
  assign hit       = !isa_aen && (addr_diff[10:3] == 8'h00);
  assign off       = addr_diff[2:0];
  assign wr_stb    = hit && isa_iow && !iow_q;

  // Host register file; CAMAC read data lands in the input bytes
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      out_lo  <= '0;
      out_hi  <= '0;
      in_lo   <= '0;
      in_hi   <= '0;
      rg2b    <= '0;
      addr_lo <= '0;
      addr_hi <= '0;
    end else begin
      if (rsp.cap_vld) {in_hi, in_lo} <= rsp.cap_data;
      if (wr_stb) begin
        case (off)
          OFF_DATA_LO: out_lo  <= isa_data;
          OFF_RG2B:    rg2b    <= isa_data;
          OFF_DATA_HI: out_hi  <= isa_data;
          OFF_ADDR_LO: addr_lo <= isa_data;
          OFF_ADDR_HI: addr_hi <= isa_data[3:0];
          default: ;
        endcase
      end
    end
  end

  // Read-back mux
  always_comb begin
    rd_data = 8'h00;
    case (off)
      OFF_DATA_LO: rd_data = in_lo;
      OFF_RG2B:    rd_data = rg2b;
      OFF_DATA_HI: rd_data = in_hi;
      OFF_ADDR_LO: rd_data = addr_lo;
      OFF_ADDR_HI: rd_data = {4'h0, addr_hi};
      OFF_STATUS:  rd_data = status_byte(rsp, ~cb_zk4);
      default:     rd_data = 8'h00;
    endcase
  end

  assign rd_oe     = hit && !isa_ior;
  assign q_r_debug = rd_oe;
  assign isa_data  = rd_oe ? rd_data : 8'hzz;

  // Request bundle toward the transfer engine
  always_comb begin
    req       = '0;
    req.start = wr_stb && (off == OFF_START);
    req.dir   = rg2b[RG2B_DIR];
    req.addr  = {addr_hi, addr_lo};
    req.wdata = {out_hi, out_lo};
  end

  sm2201_camac_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .isa_clk  (isa_clk),
    .isa_reset(isa_reset),
    .req      (req),
    .cb_prr   (cb_prr),
    .cb_cx1   (cb_cx1),
    .cb_din   (cb_data),
    .cb_addr  (cb_addr),
    .cb_b_b1  (cb_b_b1),
    .cb_dout  (cb_dout),
    .rsp      (rsp)
  );

  assign cb_data = cb_b_b1 ? cb_dout : 16'hzzzz;

  // Data-byte access during a transfer stalls the host until the engine idles
  assign data_acc = hit && (!isa_ior || !isa_iow) &&
                    ((off == OFF_DATA_LO) || (off == OFF_DATA_HI)) && rsp.busy;

  // Sticky wait-state request, dropped once the engine is idle
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset)      chrdy_hold <= 1'b0;
    else if (!rsp.busy)  chrdy_hold <= 1'b0;
    else if (data_acc)   chrdy_hold <= 1'b1;
  end

  assign isa_chrdy = !((data_acc || chrdy_hold) && rsp.busy);

`ifdef SM2201_IRQ_EN
  assign irq_en = rg2b[RG2B_IE];
`else
  assign irq_en = 1'b0;
`endif

  assign isa_irq = (irq_en && !cb_zk4) ? IRQ_MASK : 8'h00;

endmodule

// File: tb/tb_sm2201_interface_board.sv
// Self-checking bench for sm2201_interface_board: directed scenarios plus a
// randomized mix of register accesses and CAMAC transfers against a
// behavioural model of the host-visible registers.
module tb_sm2201_interface_board;

  localparam logic [9:0] BASE = 10'h100;

  logic        isa_clk = 1'b0;
  logic        isa_reset = 1'b0;
  logic        isa_ior = 1'b1, isa_iow = 1'b1, isa_ale = 1'b0, isa_aen = 1'b0;
  logic [9:0]  isa_addr = '0;
  wire  [7:0]  isa_data;
  wire  [15:0] cb_data;
  logic        isa_chrdy, q_r_debug, cb_b_b1;
  logic [7:0]  isa_irq;
  logic [11:0] cb_addr;
  logic        cb_prr = 1'b1, cb_zk4 = 1'b1, cb_cx1 = 1'b1;

  logic [7:0]  tb_isa_val = '0;
  logic        tb_isa_oe = 1'b0;
  logic [15:0] tb_cb_val = '0;
  logic        tb_cb_oe = 1'b0;
  assign isa_data = tb_isa_oe ? tb_isa_val : 8'hzz;
  assign cb_data  = tb_cb_oe ? tb_cb_val : 16'hzzzz;

  sm2201_interface_board dut (
    .isa_clk(isa_clk), .isa_reset(isa_reset), .isa_ior(isa_ior), .isa_iow(isa_iow),
    .isa_addr(isa_addr), .isa_data(isa_data), .isa_ale(isa_ale), .isa_aen(isa_aen),
    .isa_chrdy(isa_chrdy), .isa_irq(isa_irq), .q_r_debug(q_r_debug),
    .cb_prr(cb_prr), .cb_zk4(cb_zk4), .cb_cx1(cb_cx1), .cb_data(cb_data),
    .cb_addr(cb_addr), .cb_b_b1(cb_b_b1)
  );

  always #5 isa_clk = ~isa_clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of host-visible state
  logic [15:0] m_out = '0, m_in = '0;
  logic [7:0]  m_ctrl = '0;
  logic [11:0] m_addr = '0;
  logic        m_x = 1'b0, m_q = 1'b0, m_to = 1'b0;

  task automatic model_reset();
    m_out = '0; m_in = '0; m_ctrl = '0; m_addr = '0;
    m_x = 1'b0; m_q = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_write(input logic [2:0] off, input logic [7:0] v);
    case (off)
      3'd0: m_out[7:0]   = v;
      3'd1: m_ctrl       = v;
      3'd2: m_out[15:8]  = v;
      3'd3: m_addr[7:0]  = v;
      3'd4: m_addr[11:8] = v[3:0];
      default: ;
    endcase
  endtask

  function automatic logic [7:0] exp_rd(input logic [2:0] off);
    case (off)
      3'd0: return m_in[7:0];
      3'd1: return m_ctrl;
      3'd2: return m_in[15:8];
      3'd3: return m_addr[7:0];
      3'd4: return {4'h0, m_addr[11:8]};
      3'd6: return {3'b000, ~cb_zk4, m_to, m_q, m_x, 1'b0};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_irq();
`ifdef SM2201_IRQ_EN
    return (m_ctrl[1] && !cb_zk4) ? 8'h20 : 8'h00;
`else
    return 8'h00;
`endif
  endfunction

  // Every-cycle compare: read enable follows the decoded window, IRQ follows the model
  initial begin
    logic [9:0] lat;
    logic       hit;
    lat = '0;
    forever begin
      @(posedge isa_clk);
      if (!isa_reset) lat = '0;
      else if (isa_ale) lat = isa_addr;
      #1;
      if (isa_reset) begin
        hit = !isa_aen && (lat >= BASE) && (lat <= BASE + 10'd7);
        check("q_r_debug", 32'(q_r_debug), 32'(!isa_ior && hit));
        check("isa_irq", 32'(isa_irq), 32'(exp_irq()));
      end
    end
  end

  task automatic isa_wr(input logic [2:0] off, input logic [7:0] v);
    @(negedge isa_clk); isa_addr = BASE + 10'(off); isa_ale = 1'b1;
    @(negedge isa_clk); isa_ale = 1'b0; tb_isa_val = v; tb_isa_oe = 1'b1; isa_iow = 1'b0;
    @(negedge isa_clk); isa_iow = 1'b1;
    @(posedge isa_clk); model_write(off, v);
    @(negedge isa_clk); tb_isa_oe = 1'b0;
  endtask

  task automatic isa_rd_a(input logic [9:0] a, input logic aen, output logic [7:0] v, output logic dbg);
    @(negedge isa_clk); isa_addr = a; isa_aen = aen; isa_ale = 1'b1;
    @(negedge isa_clk); isa_ale = 1'b0; isa_ior = 1'b0;
    #2; v = isa_data; dbg = q_r_debug;
    @(negedge isa_clk); isa_ior = 1'b1; isa_aen = 1'b0;
  endtask

  task automatic rd_chk(input logic [2:0] off, input string name);
    logic [7:0] v;
    logic       dbg;
    isa_rd_a(BASE + 10'(off), 1'b0, v, dbg);
    check(name, 32'(v), 32'(exp_rd(off)));
  endtask

  // One CAMAC transfer; dly<0 means cb_prr never answers. probe adds
  // timeout-length and wait-state checks on a no-answer transfer.
  task automatic do_xfer(input logic dir, input logic [11:0] a, input logic [15:0] wd,
                         input logic [15:0] cbv, input logic cx, input logic lam_n,
                         input int dly, input logic probe);
    logic [7:0] v;
    logic       dbg;
    int         k;
    isa_wr(3'd1, {6'($urandom), 1'($urandom), dir});
    isa_wr(3'd3, a[7:0]);
    isa_wr(3'd4, {4'($urandom), a[11:8]});
    isa_wr(3'd0, wd[7:0]);
    isa_wr(3'd2, wd[15:8]);
    cb_zk4 = lam_n; cb_cx1 = cx; cb_prr = 1'b1;
    isa_wr(3'd7, 8'($urandom));
    m_x = 1'b0; m_q = 1'b0; m_to = 1'b0;
    @(negedge isa_clk);
    #1;
    check("xfer_cb_addr", 32'(cb_addr), 32'(a));
    check("xfer_cb_b_b1", 32'(cb_b_b1), 32'(dir));
    if (dir) check("xfer_cb_data", 32'(cb_data), 32'(wd));
    if (dly >= 0) begin
      repeat (dly) @(negedge isa_clk);
      tb_cb_val = cbv; tb_cb_oe = !dir; cb_prr = 1'b0;
    end else if (probe) begin
      isa_addr = BASE; isa_ale = 1'b1;
      @(negedge isa_clk); isa_ale = 1'b0; isa_ior = 1'b0;
      #2; check("chrdy_busy_access", 32'(isa_chrdy), 32'(0));
      @(negedge isa_clk); isa_ior = 1'b1;
      #2; check("chrdy_hold", 32'(isa_chrdy), 32'(0));
      k = 2;
      while (cb_b_b1 && k < 100) begin @(negedge isa_clk); k++; end
      #1;
      check("timeout_len_ok", 32'((k >= 63) && (k <= 67)), 32'(1));
      check("chrdy_release", 32'(isa_chrdy), 32'(1));
    end
    k = 0;
    do begin isa_rd_a(BASE + 10'd6, 1'b0, v, dbg); k++; end while (v[0] && k < 60);
    check("xfer_done", 32'(v[0]), 32'(0));
    cb_prr = 1'b1; tb_cb_oe = 1'b0;
    if (dly >= 0) begin
      m_q = 1'b1; m_x = !cx;
      if (!dir) m_in = cbv;
    end else begin
      m_to = 1'b1;
    end
    #1;
    check("post_cb_b_b1", 32'(cb_b_b1), 32'(0));
    check("post_cb_addr", 32'(cb_addr), 32'(a));
    rd_chk(3'd6, "post_status");
    rd_chk(3'd0, "post_data_lo");
    rd_chk(3'd2, "post_data_hi");
  endtask

  initial begin
    logic [7:0] v;
    logic       dbg;
    logic [7:0] walk [8];
    walk = '{8'h00, 8'h02, 8'h04, 8'h10, 8'h20, 8'h40, 8'h80, 8'h99};

    // Reset state
    repeat (3) @(negedge isa_clk);
    check("rst_cb_b_b1", 32'(cb_b_b1), 32'(0));
    check("rst_chrdy", 32'(isa_chrdy), 32'(1));
    check("rst_irq", 32'(isa_irq), 32'(0));
    check("rst_q_r_debug", 32'(q_r_debug), 32'(0));
    check("rst_cb_addr", 32'(cb_addr), 32'(0));
    isa_reset = 1'b1;
    isa_rd_a(BASE + 10'd6, 1'b0, v, dbg);
    check("rst_status", 32'(v), 32'h00);
    check("rst_status_dbg", 32'(dbg), 32'(1));
    cb_zk4 = 1'b0;
    isa_rd_a(BASE + 10'd6, 1'b0, v, dbg);
    check("rst_status_lam", 32'(v), 32'h10);
    cb_zk4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 5) rd_chk(3'(i), "rst_reg");
      else if (i != 5) rd_chk(3'(i), "rst_reg");
    end

    // Control register walking pattern
    for (int i = 0; i < 8; i++) begin
      isa_wr(3'd1, walk[i]);
      isa_rd_a(BASE + 10'd1, 1'b0, v, dbg);
      check("rg2b_readback", 32'(v), 32'(walk[i]));
      check("rg2b_dbg", 32'(dbg), 32'(1));
    end

    // Decode boundaries: AEN high, just below and just above the window
    isa_rd_a(BASE + 10'd6, 1'b1, v, dbg);
    check("aen_ignored_dbg", 32'(dbg), 32'(0));
    isa_rd_a(BASE - 10'd1, 1'b0, v, dbg);
    check("below_window_dbg", 32'(dbg), 32'(0));
    isa_rd_a(BASE + 10'd8, 1'b0, v, dbg);
    check("above_window_dbg", 32'(dbg), 32'(0));
    isa_wr(3'd5, 8'hA5);
    isa_rd_a(BASE + 10'd5, 1'b0, v, dbg);
    check("rsvd_reads_zero", 32'(v), 32'h00);

    // CAMAC read, literal expectations
    do_xfer(1'b0, 12'h123, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 2, 1'b0);
    check("lit_cb_addr", 32'(cb_addr), 32'h123);
    isa_rd_a(BASE + 10'd0, 1'b0, v, dbg); check("lit_in_lo", 32'(v), 32'hFF);
    isa_rd_a(BASE + 10'd2, 1'b0, v, dbg); check("lit_in_hi", 32'(v), 32'hFF);
    isa_rd_a(BASE + 10'd6, 1'b0, v, dbg); check("lit_status", 32'(v), 32'h06);

    // CAMAC write with no response: timeout path, wait-state probe
    do_xfer(1'b1, 12'h456, 16'hA55A, 16'h0000, 1'b1, 1'b1, -1, 1'b1);
    isa_rd_a(BASE + 10'd6, 1'b0, v, dbg); check("lit_status_to", 32'(v), 32'h08);

    // Reset in the middle of a strobe wait
    isa_wr(3'd1, 8'h01);
    isa_wr(3'd7, 8'h00);
    repeat (10) @(negedge isa_clk);
    check("pre_rst_cb_b_b1", 32'(cb_b_b1), 32'(1));
    #2 isa_reset = 1'b0;
    #1;
    check("midrst_cb_b_b1", 32'(cb_b_b1), 32'(0));
    check("midrst_cb_addr", 32'(cb_addr), 32'(0));
    check("midrst_chrdy", 32'(isa_chrdy), 32'(1));
    model_reset();
    @(negedge isa_clk); isa_reset = 1'b1;
    for (int i = 0; i < 8; i++) rd_chk(3'(i), "midrst_reg");

    // Randomized mix
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        isa_wr(3'($urandom_range(0, 6)), 8'($urandom));
      end else if (r <= 6) begin
        rd_chk(3'($urandom_range(0, 7)), "rand_read");
      end else begin
        do_xfer(1'($urandom), 12'($urandom), 16'($urandom), 16'($urandom),
                1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 30)), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, expected finish before 1ms");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

endmodule
